// File: rtl/adpcm_main_mul_pipe.sv
// adpcm_main_mul_pipe
// Elastic, NUM_STAGE-deep fixed-point multiplier with per-operand signedness,
// optional round-half-up right shift and saturation to a signed DOUT_WIDTH result.
// Stage 0 registers the exact product; the round/shift/saturate step feeds stage 1,
// and any further stages simply carry the finished result. With a single stage
// the whole computation sits in front of that one register.
module adpcm_main_mul_pipe #(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 15,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 1,
  parameter int DOUT_WIDTH  = 31,
  parameter int NUM_STAGE   = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  // Exact product width, and a compare width wide enough for both the rounded
  // product and the saturation limits.
  localparam int W   = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int CW  = (W + 1 > DOUT_WIDTH + 1) ? W + 1 : DOUT_WIDTH + 1;
  localparam int RW  = DOUT_WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [CW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? (CW'(1) <<< RSH) : '0;
  localparam logic signed [CW-1:0] MAXV = {{(CW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  // Round, arithmetic shift and clamp one exact product; returns {sat, dout}.
  function automatic logic [RW-1:0] post_proc(input logic signed [W-1:0] p);
    logic signed [CW-1:0] pc;
    logic signed [CW-1:0] r;
    logic [RW-1:0]        res;
    pc = CW'(p) + RND;
    r  = pc >>> SHIFT;
    if (r > MAXV) begin
      res = {1'b1, MAXV[DOUT_WIDTH-1:0]};
    end else if (r < MINV) begin
      res = {1'b1, MINV[DOUT_WIDTH-1:0]};
    end else begin
      res = {1'b0, r[DOUT_WIDTH-1:0]};
    end
    return res;
  endfunction

  // Operands widened by one bit so signed and unsigned inputs share one signed multiply.
  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [W-1:0]        a_w;
  logic signed [W-1:0]        b_w;
  logic signed [W-1:0]        prod_c;

  assign a_ext  = {(DIN0_SIGNED != 0) & din0[DIN0_WIDTH-1], din0};
  assign b_ext  = {(DIN1_SIGNED != 0) & din1[DIN1_WIDTH-1], din1};
  assign a_w    = W'(a_ext);
  assign b_w    = W'(b_ext);
  assign prod_c = a_w * b_w;

  // Handshake state: one valid bit per stage.
  logic [NUM_STAGE-1:0] v_q;
  logic [NUM_STAGE-1:0] v_d;
  logic [NUM_STAGE-1:0] load;
  logic                 down_ready;
  logic [RW-1:0]        res_out;

  // Ready chain walked from the output back to the input, then next-state valids.
  always_comb begin
    v_d        = v_q;
    load       = '0;
    down_ready = out_ready;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      load[k]    = !v_q[k] || down_ready;
      down_ready = load[k];
    end
    if (load[0]) v_d[0] = in_valid;
    for (int k = 1; k < NUM_STAGE; k++) begin
      if (load[k]) v_d[k] = v_q[k-1];
    end
  end

  // Stage valid bits; in-flight data is dropped on reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) v_q <= '0;
    else           v_q <= v_d;
  end

  generate
    if (NUM_STAGE == 1) begin : g_single
      logic [RW-1:0] res_q;

      // Single register: full arithmetic in front of it.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)               res_q <= '0;
        else if (load[0] && in_valid) res_q <= post_proc(prod_c);
      end

      assign res_out = res_q;
    end else begin : g_multi
      logic signed [W-1:0] prod_q;
      logic [RW-1:0]       res_q [1:NUM_STAGE-1];

      // Product in stage 0, finished result in stage 1, plain carry afterwards.
      // Payloads only move when a real item moves, so a stalled output holds steady.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          prod_q <= '0;
          for (int k = 1; k < NUM_STAGE; k++) res_q[k] <= '0;
        end else begin
          if (load[0] && in_valid) prod_q   <= prod_c;
          if (load[1] && v_q[0])   res_q[1] <= post_proc(prod_q);
          for (int k = 2; k < NUM_STAGE; k++) begin
            if (load[k] && v_q[k-1]) res_q[k] <= res_q[k-1];
          end
        end
      end

      assign res_out = res_q[NUM_STAGE-1];
    end
  endgenerate

  assign in_ready            = load[0];
  assign out_valid           = v_q[NUM_STAGE-1];
  assign {sat_flag, dout}    = res_out;

endmodule

// File: tb/tb_adpcm_main_mul_pipe.sv
// tb_adpcm_main_mul_pipe
// Four configurations share one input stream: defaults (A), signed 16-bit output
// without shift (B), shift 4 with rounding (C) and shift 4 truncating (D).
// Expected results come from plain integer arithmetic and a FIFO of accepted items.
module tb_adpcm_main_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] din0;
  logic [14:0] din1;

  logic        ir_a, ir_b, ir_c, ir_d;
  logic        ov_a, ov_b, ov_c, ov_d;
  logic [30:0] dout_a;
  logic [15:0] dout_b, dout_c, dout_d;
  logic        sat_a, sat_b, sat_c, sat_d;

  logic in_rdy;
  logic out_vld;
  assign in_rdy  = ir_a & ir_b & ir_c & ir_d;
  assign out_vld = ov_a | ov_b | ov_c | ov_d;

  adpcm_main_mul_pipe u_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
    .din0(din0), .din1(din1), .out_valid(ov_a), .out_ready(out_ready),
    .dout(dout_a), .sat_flag(sat_a));

  adpcm_main_mul_pipe #(.DIN1_SIGNED(1), .DOUT_WIDTH(16)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
    .din0(din0), .din1(din1), .out_valid(ov_b), .out_ready(out_ready),
    .dout(dout_b), .sat_flag(sat_b));

  adpcm_main_mul_pipe #(.DIN1_SIGNED(1), .SHIFT(4), .ROUND(1), .DOUT_WIDTH(16)) u_c (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c),
    .din0(din0), .din1(din1), .out_valid(ov_c), .out_ready(out_ready),
    .dout(dout_c), .sat_flag(sat_c));

  adpcm_main_mul_pipe #(.DIN1_SIGNED(1), .SHIFT(4), .ROUND(0), .DOUT_WIDTH(16)) u_d (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_d),
    .din0(din0), .din1(din1), .out_valid(ov_d), .out_ready(out_ready),
    .dout(dout_d), .sat_flag(sat_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0][63:0] d;
    logic [3:0]       s;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Integer reference: multiply, optional round-half-up, arithmetic shift, clamp.
  function automatic void model(input longint a, input longint b, input int sh,
                                input int rnd, input int dw,
                                output logic [63:0] d, output logic s);
    longint p, r, mx, mn;
    p = a * b;
    if (rnd != 0 && sh > 0) p = p + (longint'(1) <<< (sh - 1));
    r  = p >>> sh;
    mx = (longint'(1) <<< (dw - 1)) - 1;
    mn = -(longint'(1) <<< (dw - 1));
    s  = 1'b0;
    if (r > mx) begin
      r = mx; s = 1'b1;
    end else if (r < mn) begin
      r = mn; s = 1'b1;
    end
    d = 64'(r & ((longint'(1) <<< dw) - 1));
  endfunction

  function automatic exp_t mk(input logic [15:0] a, input logic [14:0] b);
    exp_t e;
    logic [63:0] d;
    logic s;
    model(longint'($signed(a)), longint'(b), 0, 1, 31, d, s);
    e.d[0] = d; e.s[0] = s;
    model(longint'($signed(a)), longint'($signed(b)), 0, 1, 16, d, s);
    e.d[1] = d; e.s[1] = s;
    model(longint'($signed(a)), longint'($signed(b)), 4, 1, 16, d, s);
    e.d[2] = d; e.s[2] = s;
    model(longint'($signed(a)), longint'($signed(b)), 4, 0, 16, d, s);
    e.d[3] = d; e.s[3] = s;
    return e;
  endfunction

  // One clock: check any presented result against the FIFO head, record accepts.
  task automatic tick();
    exp_t e;
    #1;
    if (out_vld) begin
      chk("result_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q[0];
        chk("dout_a", 64'(dout_a), e.d[0]);
        chk("sat_a",  64'(sat_a),  64'(e.s[0]));
        chk("dout_b", 64'(dout_b), e.d[1]);
        chk("sat_b",  64'(sat_b),  64'(e.s[1]));
        chk("dout_c", 64'(dout_c), e.d[2]);
        chk("sat_c",  64'(sat_c),  64'(e.s[2]));
        chk("dout_d", 64'(dout_d), e.d[3]);
        chk("sat_d",  64'(sat_d),  64'(e.s[3]));
        if (out_ready) void'(q.pop_front());
      end
    end
    last_acc = in_valid && in_rdy;
    if (last_acc) q.push_back(mk(din0, din1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] a, input logic [14:0] b);
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic flush(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  // Accept one item on an idle pipe and confirm it appears after exactly 3 edges.
  task automatic lat_probe(input string tag, input logic [15:0] a, input logic [14:0] b);
    send(a, b);
    chk({tag, "_lat1"}, 64'(out_vld), 64'd0);
    tick();
    chk({tag, "_lat2"}, 64'(out_vld), 64'd0);
    tick();
    chk({tag, "_lat3"}, 64'(out_vld), 64'd1);
    tick();
  endtask

  initial begin
    int idx;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    last_acc  = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_vld), 64'd0);
    chk("rst_dout_a", 64'(dout_a), 64'd0);
    chk("rst_sat_a", 64'(sat_a), 64'd0);
    chk("rst_in_ready", 64'(in_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: -3 * 5 with latency check
    lat_probe("t1", 16'hFFFD, 15'd5);
    flush("t1_flush");

    // T2: extreme product, then zero
    send(16'h8000, 15'h7FFF);
    send(16'h8000, 15'd0);
    flush("t2_flush");

    // T3 / T4: saturation and rounding corners
    send(16'd300, 15'd300);
    send(-16'sd300, 15'd300);
    send(16'd24, 15'd1);
    send(-16'sd24, 15'd1);
    send(16'd7, 15'd1);
    send(16'd8, 15'd1);
    flush("t34_flush");

    // T5: stall with out_ready low, capacity 3, then back-to-back drain
    out_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      din0 = 16'(idx);
      din1 = 15'd1;
      #1;
      chk("t5_in_ready", 64'(in_rdy), 64'(c < 3));
      tick();
      if (last_acc) idx++;
    end
    chk("t5_accepts", 64'(idx), 64'd4);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx <= 6);
      din0 = 16'(idx);
      din1 = 15'd1;
      #1;
      chk("t5_back_to_back", 64'(out_vld), 64'd1);
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("t5_all_accepted", 64'(idx), 64'd7);
    chk("t5_all_drained", 64'(q.size()), 64'd0);

    // T6: asynchronous reset with two results in flight
    out_ready = 1'b0;
    send(16'd11, 15'd3);
    send(16'd12, 15'd3);
    tick();
    tick();
    chk("t6_pre_valid", 64'(out_vld), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_vld), 64'd0);
    chk("t6_rst_dout_a", 64'(dout_a), 64'd0);
    chk("t6_rst_sat_a", 64'(sat_a), 64'd0);
    chk("t6_rst_dout_b", 64'(dout_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_stale", 64'(out_vld), 64'd0);
    end
    lat_probe("t6", 16'd100, 15'd7);
    flush("t6_flush");

    // Randomized traffic with random backpressure and operand corners
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 4))
        0:       din0 = 16'h8000;
        1:       din0 = 16'h7FFF;
        default: din0 = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       din1 = 15'h4000;
        1:       din1 = 15'h3FFF;
        default: din1 = 15'($urandom);
      endcase
      tick();
    end
    flush("rand_flush");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
